// File: rtl/mux8_arb_pkg.sv
// Shared constants, state encoding and one-hot helper for the mux8 round-robin arbiter.
// Pure declarations with no latency; backpressure does not apply.
package mux8_arb_pkg;

  localparam int N_REQ = 8;
  localparam int SEL_W = 3;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_OWN  = 1'b1
  } arb_state_t;

  function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] i);
    return N_REQ'(1) << i;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating priority encoder: first set req bit at base, base+1, ... (mod 8).
// Purely combinational; no backpressure.
module rr_pick
  import mux8_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] base,
  output logic             found,
  output logic [SEL_W-1:0] idx
);

  // Scan farthest offset first so the offset closest to base overwrites last.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req[base + k[SEL_W-1:0]]) begin
        found = 1'b1;
        idx   = base + k[SEL_W-1:0];
      end
    end
  end

endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin owner select for mux8 with hold limit; grant one edge after req, handover without idle bubble.
// Owner holds until done, req drop, or hold limit with another requester waiting; losers just keep req high.
module mux8_rr_arbiter
  import mux8_arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [SEL_W-1:0] sel,
  output logic [N_REQ-1:0] grant,
  output logic             valid,
  output logic [3:0]       hold_cnt
);

  localparam logic [3:0] HOLD_MAX = 4'(MAX_HOLD);

  arb_state_t       state, state_nxt;
  logic [SEL_W-1:0] ptr, ptr_nxt, base, pick_idx, sel_nxt;
  logic [N_REQ-1:0] grant_nxt;
  logic             pick_found, valid_nxt, release_now;
  logic [3:0]       hold_nxt;

  // During a release the search starts just past the owner, making it last in line.
  assign base = (state == ARB_OWN) ? sel + 3'd1 : ptr;

  assign release_now = done || !req[sel] ||
                       ((hold_cnt == HOLD_MAX) && ((req & ~grant) != '0));

  rr_pick u_pick (
    .req   (req),
    .base  (base),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ARB_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ARB_IDLE: if (pick_found) state_nxt = ARB_OWN;
      ARB_OWN:  if (release_now && !pick_found) state_nxt = ARB_IDLE;
      default:  state_nxt = ARB_IDLE;
    endcase
  end

  always_comb begin
    sel_nxt   = sel;
    grant_nxt = grant;
    valid_nxt = valid;
    hold_nxt  = hold_cnt;
    ptr_nxt   = ptr;
    unique case (state)
      ARB_IDLE: begin
        if (pick_found) begin
          sel_nxt   = pick_idx;
          grant_nxt = onehot(pick_idx);
          valid_nxt = 1'b1;
          hold_nxt  = 4'd1;
        end
      end
      ARB_OWN: begin
        if (release_now) begin
          ptr_nxt = sel + 3'd1;
          if (pick_found) begin
            sel_nxt   = pick_idx;
            grant_nxt = onehot(pick_idx);
            valid_nxt = 1'b1;
            hold_nxt  = 4'd1;
          end else begin
            grant_nxt = '0;
            valid_nxt = 1'b0;
            hold_nxt  = 4'd0;
          end
        end else if (hold_cnt != HOLD_MAX) begin
          hold_nxt = hold_cnt + 4'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel      <= '0;
      grant    <= '0;
      valid    <= 1'b0;
      hold_cnt <= '0;
      ptr      <= '0;
    end else begin
      sel      <= sel_nxt;
      grant    <= grant_nxt;
      valid    <= valid_nxt;
      hold_cnt <= hold_nxt;
      ptr      <= ptr_nxt;
    end
  end

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Scoreboard bench for mux8_rr_arbiter: each driven cycle queues the expected outputs,
// a monitor pops and compares them one step after the following rising edge.
module tb_mux8_rr_arbiter;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic       done;
  logic [2:0] sel;
  logic [7:0] grant;
  logic       valid;
  logic [3:0] hold_cnt;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    string      tag;
    logic       v;
    logic [2:0] s;
    logic [3:0] h;
  } exp_t;

  exp_t sb_q[$];

  mux8_rr_arbiter #(.MAX_HOLD(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .done     (done),
    .sel      (sel),
    .grant    (grant),
    .valid    (valid),
    .hold_cnt (hold_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, want);
  endtask

  // Drive one cycle of stimulus and queue the outputs expected after the next edge.
  task automatic cyc(input logic [7:0] r, input logic d, input logic v,
                     input logic [2:0] s, input logic [3:0] h, input string tag);
    exp_t e;
    @(negedge clk);
    req  = r;
    done = d;
    e.tag = tag;
    e.v   = v;
    e.s   = s;
    e.h   = h;
    sb_q.push_back(e);
    @(posedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst  = 1'b1;
    req  = '0;
    done = 1'b0;
    @(negedge clk);
    rst  = 1'b0;
  endtask

  always begin
    exp_t e;
    logic [7:0] g_exp;
    @(posedge clk);
    #1;
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      g_exp = 8'h00;
      if (e.v) g_exp[e.s] = 1'b1;
      chk_eq({e.tag, "_valid"}, 32'(valid), 32'(e.v));
      chk_eq({e.tag, "_grant"}, 32'(grant), 32'(g_exp));
      chk_eq({e.tag, "_hold"},  32'(hold_cnt), 32'(e.h));
      if (e.v) chk_eq({e.tag, "_sel"}, 32'(sel), 32'(e.s));
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst  = 1'b1;
    req  = '0;
    done = 1'b0;
    #12;
    chk_eq("rst_valid", 32'(valid), 32'd0);
    chk_eq("rst_grant", 32'(grant), 32'd0);
    chk_eq("rst_hold",  32'(hold_cnt), 32'd0);
    chk_eq("rst_sel",   32'(sel), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Single request, then release to idle
    cyc(8'h08, 1'b0, 1'b1, 3'd3, 4'd1, "single");
    cyc(8'h00, 1'b1, 1'b0, 3'd0, 4'd0, "single_done");
    cyc(8'h00, 1'b0, 1'b0, 3'd0, 4'd0, "idle");

    // Round-robin with done every owned cycle
    do_reset();
    for (int i = 0; i < 9; i++)
      cyc(8'hFF, 1'b1, 1'b1, 3'(i % 8), 4'd1, "rr");
    cyc(8'h00, 1'b1, 1'b0, 3'd0, 4'd0, "rr_end");

    // Hold limit forces rotation between 0 and 2
    do_reset();
    for (int i = 0; i < 9; i++) begin
      if (i < 4)      cyc(8'h05, 1'b0, 1'b1, 3'd0, 4'(i + 1), "hold");
      else if (i < 8) cyc(8'h05, 1'b0, 1'b1, 3'd2, 4'(i - 3), "hold");
      else            cyc(8'h05, 1'b0, 1'b1, 3'd0, 4'd1, "hold");
    end
    // Lone requester keeps the mux with hold_cnt saturated
    for (int i = 0; i < 12; i++)
      cyc(8'h01, 1'b0, 1'b1, 3'd0, (i + 2 > 4) ? 4'd4 : 4'(i + 2), "hold_sat");
    cyc(8'h00, 1'b1, 1'b0, 3'd0, 4'd0, "hold_end");

    // Wrap past 7 and old owner searched last
    do_reset();
    cyc(8'h80, 1'b0, 1'b1, 3'd7, 4'd1, "wrap_own7");
    cyc(8'h81, 1'b1, 1'b1, 3'd0, 4'd1, "wrap_7to0");
    cyc(8'h40, 1'b0, 1'b1, 3'd6, 4'd1, "wrap_own6");
    cyc(8'h41, 1'b1, 1'b1, 3'd0, 4'd1, "wrap_6to0");
    cyc(8'h00, 1'b1, 1'b0, 3'd0, 4'd0, "wrap_end");

    // Owner drops its request with another pending (ptr is 1 here)
    cyc(8'h10, 1'b0, 1'b1, 3'd4, 4'd1, "drop_own4");
    cyc(8'h12, 1'b0, 1'b1, 3'd4, 4'd2, "drop_hold");
    cyc(8'h02, 1'b0, 1'b1, 3'd1, 4'd1, "drop_to1");
    cyc(8'h00, 1'b1, 1'b0, 3'd0, 4'd0, "drop_end");

    // done coinciding with hold expiry is one release
    do_reset();
    for (int i = 0; i < 4; i++)
      cyc(8'h03, 1'b0, 1'b1, 3'd0, 4'(i + 1), "dh_hold");
    cyc(8'h03, 1'b1, 1'b1, 3'd1, 4'd1, "dh_release");
    cyc(8'h00, 1'b1, 1'b0, 3'd0, 4'd0, "dh_end");

    // Async reset mid-transaction, with ptr parked at 7 beforehand
    do_reset();
    cyc(8'h40, 1'b0, 1'b1, 3'd6, 4'd1, "ar_own6");
    cyc(8'h20, 1'b0, 1'b1, 3'd5, 4'd1, "ar_own5");
    cyc(8'h20, 1'b0, 1'b1, 3'd5, 4'd2, "ar_hold2");
    cyc(8'h20, 1'b0, 1'b1, 3'd5, 4'd3, "ar_hold3");
    #3;
    rst = 1'b1;
    req = '0;
    #1;
    chk_eq("ar_valid", 32'(valid), 32'd0);
    chk_eq("ar_grant", 32'(grant), 32'd0);
    chk_eq("ar_hold",  32'(hold_cnt), 32'd0);
    chk_eq("ar_sel",   32'(sel), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    cyc(8'hA0, 1'b0, 1'b1, 3'd5, 4'd1, "ar_first");
    cyc(8'hA0, 1'b1, 1'b1, 3'd7, 4'd1, "ar_next");

    #2;
    chk_eq("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
